// File: rtl/copyread_scheduler.sv
// Per-BRAM write scheduler: arbitrates a recycle FIFO (priority, burst-limited) against
// NUM_REQ round-robin copy-read requesters, emitting one registered write per cycle.
module copyread_scheduler #(
  parameter int NUM_REQ   = 16,
  parameter int IDX_W     = 4,
  parameter int ADDR_W    = 9,
  parameter int BE_W      = 8,
  parameter int DATA_W    = 64,
  parameter int RCY_DEPTH = 4,
  parameter int RCY_BURST = 4,
  localparam int CMD_W    = ADDR_W + BE_W + DATA_W,
  localparam int CNT_W    = $clog2(RCY_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ*CMD_W-1:0] req_cmd,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [CMD_W-1:0]         rcy_cmd,
  input  logic                     rcy_valid,
  output logic                     rcy_ready,
  input  logic                     bram_stall,
  output logic                     bram_we,
  output logic [ADDR_W-1:0]        bram_addr,
  output logic [BE_W-1:0]          bram_be,
  output logic [DATA_W-1:0]        bram_data,
  output logic [IDX_W-1:0]         grant_idx,
  output logic [CNT_W-1:0]         rcy_count
);
  localparam int PTR_W = $clog2(RCY_DEPTH);
  localparam int BC_W  = $clog2(RCY_BURST + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] data;
  } cmd_t;

  cmd_t [NUM_REQ-1:0] req_arr;
  assign req_arr = req_cmd;

  cmd_t              mem [RCY_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [BC_W-1:0]   burst_cnt;
  logic [IDX_W-1:0]  base;
  cmd_t              out_cmd;

  // Round-robin pick: lowest valid index >= base, else lowest valid index overall.
  logic [IDX_W-1:0] lo_idx, hi_idx, rr_idx;
  logic             hi_hit;
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    hi_hit = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) lo_idx = IDX_W'(i);
      if (req_valid[i] && (i >= int'(base))) begin
        hi_idx = IDX_W'(i);
        hi_hit = 1'b1;
      end
    end
    rr_idx = hi_hit ? hi_idx : lo_idx;
  end

  logic any_req, fifo_empty, sel_fifo, sel_req, rcy_push, fifo_pop;
  assign any_req    = |req_valid;
  assign fifo_empty = (count == '0);
  assign sel_fifo   = rst_n && !bram_stall && !fifo_empty &&
                      ((burst_cnt < BC_W'(RCY_BURST)) || !any_req);
  assign sel_req    = rst_n && !bram_stall && !sel_fifo && any_req;
  assign fifo_pop   = sel_fifo;
  // Ready comes from the registered count only, so a full FIFO refuses even while draining.
  assign rcy_ready  = rst_n && (count < CNT_W'(RCY_DEPTH));
  assign rcy_push   = rcy_valid && rcy_ready;
  assign req_ready  = sel_req ? (NUM_REQ'(1) << rr_idx) : '0;

  always_ff @(posedge clk) begin
    if (rcy_push) mem[wr_ptr] <= rcy_cmd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      burst_cnt <= '0;
      base      <= '0;
      grant_idx <= '0;
      bram_we   <= 1'b0;
      out_cmd   <= '0;
    end else begin
      if (rcy_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({rcy_push, fifo_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (!bram_stall) begin
        if (sel_fifo) begin
          bram_we   <= 1'b1;
          out_cmd   <= mem[rd_ptr];
          burst_cnt <= any_req ? burst_cnt + 1'b1 : '0;
        end else if (sel_req) begin
          bram_we   <= 1'b1;
          out_cmd   <= req_arr[rr_idx];
          grant_idx <= rr_idx;
          base      <= (rr_idx == IDX_W'(NUM_REQ - 1)) ? '0 : rr_idx + 1'b1;
          burst_cnt <= '0;
        end else begin
          bram_we   <= 1'b0;
        end
      end
    end
  end

  assign bram_addr = out_cmd.addr;
  assign bram_be   = out_cmd.be;
  assign bram_data = out_cmd.data;
  assign rcy_count = count;
endmodule

// File: tb/tb_copyread_scheduler.sv
// Scoreboard bench for copyread_scheduler: a cycle model predicts grants, pushes expected writes,
// and pops them against the registered BRAM outputs; directed checks cover the key scenarios.
module tb_copyread_scheduler;
  localparam int NR = 16;
  localparam int CW = 81;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NR-1:0][CW-1:0] cmds;
  logic [NR*CW-1:0]     req_cmd;
  logic [NR-1:0]        req_valid, req_ready;
  logic [CW-1:0]        rcy_cmd;
  logic                 rcy_valid, rcy_ready, bram_stall, bram_we;
  logic [8:0]           bram_addr;
  logic [7:0]           bram_be;
  logic [63:0]          bram_data;
  logic [3:0]           grant_idx;
  logic [2:0]           rcy_count;

  assign req_cmd = cmds;
  always #5 clk = ~clk;

  copyread_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req_cmd(req_cmd), .req_valid(req_valid), .req_ready(req_ready),
    .rcy_cmd(rcy_cmd), .rcy_valid(rcy_valid), .rcy_ready(rcy_ready), .bram_stall(bram_stall),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_be(bram_be), .bram_data(bram_data),
    .grant_idx(grant_idx), .rcy_count(rcy_count)
  );

  int n_cmp = 0, n_err = 0;
  logic [CW-1:0] m_fifo[$];
  logic [CW-1:0] exp_q[$];
  int            m_base, m_burst;
  logic          e_we;
  logic [CW-1:0] e_cmd;
  logic [3:0]    e_grant;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] rnd_cmd();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[CW-1:0];
  endfunction

  // One clock: check combinational handshakes, advance model at the edge, check registered outputs.
  task automatic cycle();
    bit any, fsel, rsel, enq;
    int idx;
    logic [NR-1:0] er;
    #1;
    any = |req_valid;
    idx = -1;
    for (int k = 0; k < NR; k++)
      if (idx < 0 && req_valid[(m_base + k) % NR]) idx = (m_base + k) % NR;
    fsel = rst_n && !bram_stall && (m_fifo.size() > 0) && (m_burst < 4 || !any);
    rsel = rst_n && !bram_stall && !fsel && any;
    er   = rsel ? (NR'(1) << idx) : '0;
    chk("req_ready", req_ready, er);
    chk("rcy_ready", rcy_ready, rst_n && (m_fifo.size() < 4));
    enq = rcy_valid && rst_n && (m_fifo.size() < 4);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_fifo.delete(); exp_q.delete();
      m_base = 0; m_burst = 0; e_we = 0; e_cmd = '0; e_grant = '0;
    end else begin
      if (!bram_stall) begin
        if (fsel) begin
          exp_q.push_back(m_fifo.pop_front());
          m_burst = any ? m_burst + 1 : 0;
        end else if (rsel) begin
          exp_q.push_back(cmds[idx]);
          m_base  = (idx + 1) % NR;
          e_grant = idx[3:0];
          m_burst = 0;
          cmds[idx] = rnd_cmd();
        end else e_we = 0;
      end
      if (enq) begin
        m_fifo.push_back(rcy_cmd);
        rcy_cmd = rnd_cmd();
      end
    end
    if (exp_q.size() > 0) begin
      e_cmd = exp_q.pop_front();
      e_we  = 1;
    end
    chk("bram_we", bram_we, e_we);
    chk("bram_cmd", {bram_addr, bram_be, bram_data}, e_cmd);
    chk("grant_idx", grant_idx, e_grant);
    chk("rcy_count", rcy_count, m_fifo.size());
  endtask

  initial begin
    logic [8:0] a0;
    rst_n = 0; req_valid = '0; rcy_valid = 0; bram_stall = 0;
    rcy_cmd = rnd_cmd();
    for (int i = 0; i < NR; i++) cmds[i] = rnd_cmd();
    m_base = 0; m_burst = 0; e_we = 0; e_cmd = '0; e_grant = '0;
    repeat (2) cycle();
    chk("reset_we", bram_we, 0);
    chk("reset_cnt", rcy_count, 0);

    // T1: single requester from reset
    rst_n = 1; req_valid = 16'h0001; a0 = cmds[0][CW-1 -: 9];
    cycle();
    chk("t1_we", bram_we, 1);
    chk("t1_addr", bram_addr, a0);
    chk("t1_grant", grant_idx, 0);
    req_valid = '0; cycle();

    // T2: all requesting, strict rotation 0..15,0
    rst_n = 0; cycle(); rst_n = 1; req_valid = '1;
    for (int k = 0; k < 17; k++) begin
      cycle();
      chk("t2_grant", grant_idx, k % 16);
      chk("t2_we", bram_we, 1);
    end
    req_valid = '0; cycle();

    // T3: wrap from base=5
    rst_n = 0; cycle(); rst_n = 1; req_valid = 16'h0010;
    cycle(); chk("t3_g4", grant_idx, 4);
    req_valid = 16'h0011;
    cycle(); chk("t3_wrap", grant_idx, 0);
    cycle(); chk("t3_next", grant_idx, 4);

    // T4: fill FIFO under stall, then burst-limited drain with a refill
    bram_stall = 1; req_valid = 16'h0004; rcy_valid = 1;
    repeat (4) cycle();
    chk("t4_full_ready", rcy_ready, 0);
    chk("t4_full_cnt", rcy_count, 4);
    bram_stall = 0;
    cycle(); cycle();
    rcy_valid = 0;
    cycle(); cycle();
    chk("t4_no_req_yet", grant_idx, 4);
    cycle();
    chk("t4_req2", grant_idx, 2);
    chk("t4_left", rcy_count, 1);
    cycle(); chk("t4_fifo5_cnt", rcy_count, 0);
    cycle(); chk("t4_req2_again", grant_idx, 2);
    req_valid = '0; cycle();

    // T5: stall mid-stream, enqueue continues
    req_valid = '1;
    repeat (3) cycle();
    bram_stall = 1; rcy_valid = 1;
    repeat (3) cycle();
    chk("t5_held_we", bram_we, 1);
    chk("t5_cnt", rcy_count, 3);
    bram_stall = 0; rcy_valid = 0;
    repeat (6) cycle();

    // T6: reset with FIFO occupied and a write pending
    cycle();
    bram_stall = 1; rcy_valid = 1;
    repeat (3) cycle();
    chk("t6_pre_cnt", rcy_count, 3);
    chk("t6_pre_we", bram_we, 1);
    rst_n = 0; bram_stall = 0; rcy_valid = 0;
    cycle();
    chk("t6_we", bram_we, 0);
    chk("t6_cnt", rcy_count, 0);
    rst_n = 1; req_valid = '0;
    repeat (4) cycle();
    chk("t6_idle", bram_we, 0);
    req_valid = 16'h0101;
    cycle(); chk("t6_base0", grant_idx, 0);

    // Random mix against the model
    for (int c = 0; c < 300; c++) begin
      req_valid  = ($urandom_range(0, 3) == 0) ? '0 : NR'($urandom());
      rcy_valid  = $urandom_range(0, 1) == 1;
      bram_stall = $urandom_range(0, 3) == 0;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
